// File: rtl/fb_mem_pkg.sv
// rtl/fb_mem_pkg.sv - shared frame-buffer BRAM constants, op codes, client slots, fetch FSM encoding
//
// Purpose : common definitions for clients of the frame-buffer BRAM arbiter.
// Ports   : none (package).
package fb_mem_pkg;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 32;
  localparam int OP_W   = 4;

  localparam logic [OP_W-1:0] OP_READ   = 4'b0000;
  localparam logic [OP_W-1:0] OP_WR_ALL = 4'b1111;

  localparam int CLIENT_FETCH    = 0;
  localparam int CLIENT_RECTFILL = 1;
  localparam int CLIENT_RECTPIX  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous return-data FIFO for the pixel fetch client
//
// Purpose : DEPTH x WIDTH FIFO, DEPTH a power of two. Head word is shown on
//           dout combinationally (zero when empty).
// Ports   : clk, rst_ (async active-low), flush (drop all entries),
//           push/din (write tail), pop (advance head), dout (head word),
//           count (entries held), empty, full.
module fetch_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_V = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_V);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pixel_fetch_client.sv
// rtl/pixel_fetch_client.sv - frame-buffer read requester feeding a pixel-word stream
//
// Purpose : walks a frame region of BRAM issuing sequential reads through the
//           arbiter rts/rtr port, captures read-back words from the broadcast
//           bus by its own strobe bit and streams them out of a credit-guarded
//           FIFO. Optional statistics counters under `PIXEL_FETCH_STATS_EN.
// Ports   : clk, rst_ (async active-low)
//           start/stop            - control pulses
//           base_addr/frame_words - frame region, sampled on start
//           mem_addr/mem_wrdata/mem_op/mem_rts_out/mem_rtr_in - request port
//           bcast_data/bcast_xfc  - arbiter read-back bus
//           pix_data/pix_rts_out/pix_rtr_in - pixel-word output stream
//           busy, frame_done      - status
//           underflow_cnt, stall_cnt - only with PIXEL_FETCH_STATS_EN
module pixel_fetch_client #(
  parameter int NUM_ENGINES = 3,
  parameter int CLIENT_IDX  = fb_mem_pkg::CLIENT_FETCH,
  parameter int FIFO_DEPTH  = 8,
  parameter int ADDR_W      = fb_mem_pkg::ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst_,
  input  logic                   start,
  input  logic                   stop,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic [ADDR_W-1:0]      frame_words,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [31:0]            mem_wrdata,
  output logic [3:0]             mem_op,
  output logic                   mem_rts_out,
  input  logic                   mem_rtr_in,
  input  logic [31:0]            bcast_data,
  input  logic [NUM_ENGINES-1:0] bcast_xfc,
  output logic [31:0]            pix_data,
  output logic                   pix_rts_out,
  input  logic                   pix_rtr_in,
  output logic                   busy,
  output logic                   frame_done
`ifdef PIXEL_FETCH_STATS_EN
  ,
  output logic [15:0]            underflow_cnt,
  output logic [15:0]            stall_cnt
`endif
);

  import fb_mem_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_V = (CNT_W+1)'(FIFO_DEPTH);

  fetch_state_t state;
  fetch_state_t state_nxt;
  logic         rts_nxt;

  logic [ADDR_W-1:0]      cur_addr;
  logic [ADDR_W-1:0]      base_q;
  logic [ADDR_W-1:0]      len_q;
  logic [ADDR_W-1:0]      word_idx;
  logic [CNT_W-1:0]       outstanding;
  logic [CNT_W-1:0]       fifo_count;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic [CNT_W:0]         committed;
  logic [NUM_ENGINES-1:0] client_mask;

  logic mxfc;
  logic pxfc;
  logic ret_hit;
  logic ret_take;
  logic launch;
  logic last_word;
  logic credit_ok;

  assign client_mask = NUM_ENGINES'(1) << CLIENT_IDX;
  assign ret_hit     = |(bcast_xfc & client_mask);

  assign mxfc      = mem_rts_out && mem_rtr_in;
  assign pxfc      = pix_rts_out && pix_rtr_in;
  assign launch    = (state == ST_IDLE) && start && !stop && (frame_words != '0);
  assign last_word = (word_idx == len_q - 1'b1);

  // Returns only count when we are actually waiting for one; stray strobes
  // while idle or with nothing in flight are dropped.
  assign ret_take = ret_hit && (state != ST_IDLE) && (outstanding != '0) && !fifo_full;

  // Every word already in the FIFO or in flight, plus the request handing
  // over right now, holds a FIFO slot. Pops this cycle are not credited until
  // they are visible in fifo_count, so the FIFO can never overflow.
  assign committed = {1'b0, fifo_count} + {1'b0, outstanding} + (CNT_W+1)'(mxfc);
  assign credit_ok = (committed < DEPTH_V);

  // The address counter itself is the request address: it only moves on a
  // handshake or on launch (when no request is pending), so it is stable
  // for as long as mem_rts_out is held.
  assign mem_addr   = cur_addr;
  assign mem_wrdata = '0;
  assign mem_op     = OP_READ;
  assign busy       = (state != ST_IDLE);
  assign frame_done = mxfc && last_word;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rts_nxt   = 1'b0;
    case (state)
      ST_IDLE:  if (launch) state_nxt = ST_FETCH;
      ST_FETCH: if (stop)   state_nxt = ST_DRAIN;
      ST_DRAIN: if (!mem_rts_out && (outstanding == '0)) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    // A pending request is held until taken, even after stop.
    if (mem_rts_out && !mem_rtr_in) rts_nxt = 1'b1;
    else if ((state == ST_FETCH) && !stop && credit_ok) rts_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      mem_rts_out <= 1'b0;
      cur_addr    <= '0;
      base_q      <= '0;
      len_q       <= '0;
      word_idx    <= '0;
      outstanding <= '0;
    end else begin
      mem_rts_out <= rts_nxt;
      if (launch) begin
        base_q   <= base_addr;
        len_q    <= frame_words;
        cur_addr <= base_addr;
        word_idx <= '0;
      end else if (mxfc) begin
        if (last_word) begin
          cur_addr <= base_q;
          word_idx <= '0;
        end else begin
          cur_addr <= cur_addr + 1'b1;
          word_idx <= word_idx + 1'b1;
        end
      end
      case ({mxfc, ret_take})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst_  (rst_),
    .flush (launch),
    .push  (ret_take),
    .pop   (pxfc),
    .din   (bcast_data),
    .dout  (pix_data),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign pix_rts_out = !fifo_empty;

`ifdef PIXEL_FETCH_STATS_EN
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      underflow_cnt <= '0;
      stall_cnt     <= '0;
    end else begin
      if (launch)
        underflow_cnt <= '0;
      else if ((state == ST_FETCH) && pix_rtr_in && fifo_empty && (underflow_cnt != 16'hFFFF))
        underflow_cnt <= underflow_cnt + 1'b1;
      if (mem_rts_out && !mem_rtr_in && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pixel_fetch_client.sv
// tb/tb_pixel_fetch_client.sv - scoreboard bench for pixel_fetch_client
module tb_pixel_fetch_client;

  localparam int AW = 17;

  logic           clk = 1'b0;
  logic           rst_;
  logic           start;
  logic           stop;
  logic [AW-1:0]  base_addr;
  logic [AW-1:0]  frame_words;
  logic [AW-1:0]  mem_addr;
  logic [31:0]    mem_wrdata;
  logic [3:0]     mem_op;
  logic           mem_rts_out;
  logic           mem_rtr_in;
  logic [31:0]    bcast_data;
  logic [2:0]     bcast_xfc;
  logic [31:0]    pix_data;
  logic           pix_rts_out;
  logic           pix_rtr_in;
  logic           busy;
  logic           frame_done;
`ifdef PIXEL_FETCH_STATS_EN
  logic [15:0]    underflow_cnt;
  logic [15:0]    stall_cnt;
`endif

  always #5 clk = ~clk;

  pixel_fetch_client dut (
    .clk         (clk),
    .rst_        (rst_),
    .start       (start),
    .stop        (stop),
    .base_addr   (base_addr),
    .frame_words (frame_words),
    .mem_addr    (mem_addr),
    .mem_wrdata  (mem_wrdata),
    .mem_op      (mem_op),
    .mem_rts_out (mem_rts_out),
    .mem_rtr_in  (mem_rtr_in),
    .bcast_data  (bcast_data),
    .bcast_xfc   (bcast_xfc),
    .pix_data    (pix_data),
    .pix_rts_out (pix_rts_out),
    .pix_rtr_in  (pix_rtr_in),
    .busy        (busy),
    .frame_done  (frame_done)
`ifdef PIXEL_FETCH_STATS_EN
    ,
    .underflow_cnt (underflow_cnt),
    .stall_cnt     (stall_cnt)
`endif
  );

  typedef struct {
    int          due;
    logic [31:0] data;
  } ret_t;

  int            tests = 0;
  int            fails = 0;
  int            cyc = 0;
  int            mxfc_cnt = 0;
  int            pop_cnt = 0;
  ret_t          ret_q[$];
  logic [31:0]   exp_pix[$];
  logic [AW-1:0] addr_log[$];
  logic          fd_log[$];
  logic [AW-1:0] m_base = '0;
  logic [AW-1:0] m_len = 17'd1;
  logic [AW-1:0] m_idx = '0;
  logic [14:0]   seq = '0;
  logic [2:0]    extra_xfc = '0;
  logic          prev_pend = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [AW-1:0] ea;
  logic [31:0]   rd;
  logic [31:0]   pe;
  ret_t          rr;

  logic [AW-1:0] t1_addr [5] = '{17'h100, 17'h101, 17'h102, 17'h103, 17'h100};
  logic          t1_fd   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [AW-1:0] t3_addr [4] = '{17'h1FFFE, 17'h1FFFF, 17'h00000, 17'h1FFFE};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Request monitor: address/frame_done model and hold-stability check;
  // each granted request schedules its read-back and its expected pixel word.
  always @(negedge clk) begin
    if (rst_ !== 1'b1) begin
      prev_pend = 1'b0;
    end else begin
      if (prev_pend) begin
        check("rts_held", {31'd0, mem_rts_out}, 32'd1);
        check("addr_held", {15'd0, mem_addr}, {15'd0, prev_addr});
      end
      prev_pend = mem_rts_out && !mem_rtr_in;
      prev_addr = mem_addr;
      if (mem_rts_out && mem_rtr_in) begin
        ea = m_base + m_idx;
        check("req_addr", {15'd0, mem_addr}, {15'd0, ea});
        check("frame_done", {31'd0, frame_done}, {31'd0, (m_idx == m_len - 1'b1)});
        check("mem_op", {28'd0, mem_op}, 32'd0);
        addr_log.push_back(mem_addr);
        fd_log.push_back(frame_done);
        m_idx = (m_idx == m_len - 1'b1) ? '0 : m_idx + 1'b1;
        rd = {seq, mem_addr};
        seq = seq + 1'b1;
        ret_q.push_back('{cyc + 3, rd});
        exp_pix.push_back(rd);
        mxfc_cnt++;
      end else if (frame_done !== 1'b0) begin
        check("frame_done_no_xfc", {31'd0, frame_done}, 32'd0);
      end
    end
  end

  // Pixel monitor: every delivered word must be the next expected one.
  always @(negedge clk) begin
    if (rst_ === 1'b1 && pix_rts_out && pix_rtr_in) begin
      if (exp_pix.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL pix_unexpected got %h expected none", pix_data);
      end else begin
        pe = exp_pix.pop_front();
        check("pix_data", pix_data, pe);
      end
      pop_cnt++;
    end
  end

  // Arbiter model: in-order read-back three cycles after each grant.
  always @(posedge clk) begin
    cyc++;
    #1;
    bcast_xfc  = extra_xfc;
    bcast_data = 32'hDEADBEEF;
    if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
      rr = ret_q.pop_front();
      bcast_xfc[0] = 1'b1;
      bcast_data   = rr.data;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic [AW-1:0] n);
    start = 1'b1;
    base_addr = b;
    frame_words = n;
    if (n != '0) begin
      m_base = b;
      m_len  = n;
      m_idx  = '0;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    exp_pix.delete();
    addr_log.delete();
    fd_log.delete();
  endtask

  task automatic wait_idle(input int limit, input string name);
    int k = 0;
    while (busy !== 1'b0 && k < limit) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(name, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_log(input int n, input int limit, input string name);
    int k = 0;
    while (addr_log.size() < n && k < limit) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(name, addr_log.size() >= n, 32'd1);
  endtask

  task automatic finish_frame(input string name);
    stop = 1'b1;
    mem_rtr_in = 1'b1;
    pix_rtr_in = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    wait_idle(200, {name, "_idle"});
    cycles(12);
    check({name, "_drained"}, exp_pix.size(), 32'd0);
    check({name, "_pix_empty"}, {31'd0, pix_rts_out}, 32'd0);
  endtask

  task automatic check_reset(input string name);
    check({name, "_rts"}, {31'd0, mem_rts_out}, 32'd0);
    check({name, "_addr"}, {15'd0, mem_addr}, 32'd0);
    check({name, "_pix_rts"}, {31'd0, pix_rts_out}, 32'd0);
    check({name, "_pix_data"}, pix_data, 32'd0);
    check({name, "_busy"}, {31'd0, busy}, 32'd0);
    check({name, "_frame_done"}, {31'd0, frame_done}, 32'd0);
    check({name, "_wrdata"}, mem_wrdata, 32'd0);
  endtask

  initial begin
    int c0;
    int p0;
    int n;
    int hold;
    rst_ = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    base_addr = '0;
    frame_words = '0;
    mem_rtr_in = 1'b0;
    pix_rtr_in = 1'b0;
    bcast_xfc = '0;
    bcast_data = '0;
    cycles(3);
    check_reset("reset");
    rst_ = 1'b1;
    cycles(2);

    // Basic frame: 0x100..0x103 then wrap, frame_done on the fourth grant.
    mem_rtr_in = 1'b1;
    pix_rtr_in = 1'b1;
    do_start(17'h100, 17'd4);
    wait_log(5, 100, "t1_grants");
    for (int i = 0; i < 5; i++) begin
      if (i < addr_log.size()) begin
        check($sformatf("t1_addr%0d", i), {15'd0, addr_log[i]}, {15'd0, t1_addr[i]});
        check($sformatf("t1_fd%0d", i), {31'd0, fd_log[i]}, {31'd0, t1_fd[i]});
      end
    end
    finish_frame("t1");

    // A zero-length start is ignored.
    do_start(17'h40, 17'd0);
    cycles(3);
    check("zero_len_ignored", {31'd0, busy}, 32'd0);
    check("zero_len_no_rts", {31'd0, mem_rts_out}, 32'd0);

    // Credit: with the consumer stalled exactly FIFO_DEPTH reads issue.
    pix_rtr_in = 1'b0;
    mem_rtr_in = 1'b1;
    c0 = mxfc_cnt;
    do_start(17'h2000, 17'd100);
    cycles(30);
    check("credit_8", mxfc_cnt - c0, 32'd8);
    check("credit_rts_low", {31'd0, mem_rts_out}, 32'd0);
    pix_rtr_in = 1'b1;
    cycles(1);
    pix_rtr_in = 1'b0;
    cycles(20);
    check("credit_9", mxfc_cnt - c0, 32'd9);
    check("credit_rts_low2", {31'd0, mem_rts_out}, 32'd0);
    finish_frame("t2");

    // Random grant stalls and consumer back-pressure, address wrap at 2^17.
    c0 = mxfc_cnt;
    hold = 0;
    do_start(17'h1FFFE, 17'd3);
    for (int i = 0; i < 250; i++) begin
      if (hold > 0) begin
        mem_rtr_in = 1'b0;
        hold--;
      end else if ($urandom_range(0, 3) == 0) begin
        mem_rtr_in = 1'b0;
        hold = $urandom_range(0, 4);
      end else begin
        mem_rtr_in = 1'b1;
      end
      pix_rtr_in = ($urandom_range(0, 2) != 0);
      cycles(1);
    end
    check("t3_progress", (mxfc_cnt - c0) >= 4, 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (i < addr_log.size())
        check($sformatf("t3_addr%0d", i), {15'd0, addr_log[i]}, {15'd0, t3_addr[i]});
    end
    finish_frame("t3");

    // Stop with reads in flight and a pending request; start alongside stop.
    pix_rtr_in = 1'b0;
    mem_rtr_in = 1'b1;
    c0 = mxfc_cnt;
    do_start(17'h300, 17'd50);
    cycles(4);
    mem_rtr_in = 1'b0;
    cycles(1);
    check("t5_pending", {31'd0, mem_rts_out}, 32'd1);
    n = mxfc_cnt - c0;
    stop = 1'b1;
    start = 1'b1;
    base_addr = 17'h5555;
    frame_words = 17'd7;
    cycles(1);
    stop = 1'b0;
    start = 1'b0;
    cycles(3);
    check("t5_still_busy", {31'd0, busy}, 32'd1);
    mem_rtr_in = 1'b1;
    wait_idle(100, "t5_idle");
    check("t5_issued", mxfc_cnt - c0, n + 1);
    check("t5_returns_done", ret_q.size(), 32'd0);
    p0 = pop_cnt;
    pix_rtr_in = 1'b1;
    cycles(n + 6);
    check("t5_words", pop_cnt - p0, n + 1);
    check("t5_start_ignored", {31'd0, busy}, 32'd0);

    // Foreign strobe bit ignored, then reset mid-frame.
    pix_rtr_in = 1'b1;
    mem_rtr_in = 1'b1;
    do_start(17'h400, 17'd16);
    extra_xfc = 3'b010;
    cycles(20);
    extra_xfc = 3'b000;
    rst_ = 1'b0;
    #2;
    check_reset("midrst");
    exp_pix.delete();
    cycles(2);
    rst_ = 1'b1;
    cycles(12);
    check("post_rst_pix_empty", {31'd0, pix_rts_out}, 32'd0);
    check("post_rst_idle", {31'd0, busy}, 32'd0);
    extra_xfc = 3'b001;
    cycles(2);
    extra_xfc = 3'b000;
    cycles(2);
    check("idle_ret_ignored", {31'd0, pix_rts_out}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
